// File: rtl/clk_divider_multi.sv
// clk_divider_multi: NCH independent, runtime-programmable clock dividers
// driven from one master clock.
//
// Each channel counts 0 .. active-1 and drives clkout high while the pre-edge
// counter is below a threshold. clkout is registered and therefore lags the
// counter by one cycle. A newly loaded ratio waits in a pending register and
// takes effect only at the channel's period boundary, so no short or runt
// pulses are produced. A common sync strobe restarts every channel at phase 0
// and applies any pending ratio at once.
//
// Optional build macro:
//   DUTY_ROUND_UP_EN  defined   -> threshold = (active+1)>>1 (odd ratios high-biased)
//                     undefined -> threshold = active>>1     (odd ratios low-biased)
//
// Ports:
//   clkin       master clock, all logic on the rising edge
//   reset       asynchronous active-high reset
//   enable      global count enable; low freezes counters and clkout, edge_rise = 0
//   sync        one-cycle strobe; restarts all channels at phase 0
//   ratio_in    per-channel new ratio, channel k at [k*B +: B]
//   ratio_load  per-channel strobe capturing the ratio_in slice as pending
//   clkout      divided clock per channel (registered)
//   edge_rise   one-cycle pulse coincident with the clkout rising cycle
//   busy        high while a loaded ratio is pending and not yet applied

module clk_divider_multi #(
  parameter int unsigned NCH           = 2,
  parameter int unsigned B             = 16,
  parameter int unsigned DEFAULT_RATIO = 3
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync,
  input  logic [NCH*B-1:0] ratio_in,
  input  logic [NCH-1:0]   ratio_load,
  output logic [NCH-1:0]   clkout,
  output logic [NCH-1:0]   edge_rise,
  output logic [NCH-1:0]   busy
);

  localparam logic [B-1:0] RATIO_MIN   = B'(2);
  localparam logic [B-1:0] RESET_RATIO = (DEFAULT_RATIO < 2) ? RATIO_MIN : B'(DEFAULT_RATIO);

  // Ratios of 0 or 1 cannot form a period with a high and a low phase.
  function automatic logic [B-1:0] clamp_ratio(input logic [B-1:0] r);
    return (r < RATIO_MIN) ? RATIO_MIN : r;
  endfunction

  // High-phase length in clkin cycles for a given ratio.
  function automatic logic [B-1:0] threshold(input logic [B-1:0] a);
`ifdef DUTY_ROUND_UP_EN
    // Widened by one bit so a ratio of all-ones does not overflow.
    return B'(({1'b0, a} + (B+1)'(1)) >> 1);
`else
    return a >> 1;
`endif
  endfunction

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_ch
      logic [B-1:0] counter_q, counter_d;
      logic [B-1:0] active_q,  active_d;
      logic [B-1:0] pending_q, pending_d;
      logic         pend_v_q,  pend_v_d;
      logic         clkout_q,  clkout_d;
      logic         edge_q,    edge_d;
      logic [B-1:0] load_val;
      logic         at_wrap;

      assign load_val = clamp_ratio(ratio_in[k*B +: B]);
      assign at_wrap  = (counter_q == (active_q - B'(1)));

      // Next-state: sync beats counting; a load is applied last so it always
      // survives as pending even when the old pending value is consumed.
      always_comb begin
        counter_d = counter_q;
        active_d  = active_q;
        pending_d = pending_q;
        pend_v_d  = pend_v_q;
        clkout_d  = clkout_q;
        edge_d    = 1'b0;

        if (sync) begin
          counter_d = '0;
          clkout_d  = 1'b0;
          if (pend_v_q) begin
            active_d = pending_q;
            pend_v_d = 1'b0;
          end
        end else if (enable) begin
          // Outputs on the apply edge still use the old active ratio.
          clkout_d = (counter_q < threshold(active_q));
          edge_d   = (counter_q == '0);
          if (at_wrap) begin
            counter_d = '0;
            if (pend_v_q) begin
              active_d = pending_q;
              pend_v_d = 1'b0;
            end
          end else begin
            counter_d = counter_q + B'(1);
          end
        end

        if (ratio_load[k]) begin
          pending_d = load_val;
          pend_v_d  = 1'b1;
        end
      end

      // Channel state register.
      always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
          counter_q <= '0;
          active_q  <= RESET_RATIO;
          pending_q <= RESET_RATIO;
          pend_v_q  <= 1'b0;
          clkout_q  <= 1'b0;
          edge_q    <= 1'b0;
        end else begin
          counter_q <= counter_d;
          active_q  <= active_d;
          pending_q <= pending_d;
          pend_v_q  <= pend_v_d;
          clkout_q  <= clkout_d;
          edge_q    <= edge_d;
        end
      end

      assign clkout[k]    = clkout_q;
      assign edge_rise[k] = edge_q;
      assign busy[k]      = pend_v_q;
    end
  endgenerate

endmodule

// File: tb/tb_clk_divider_multi.sv
`timescale 1ns/1ps

module tb_clk_divider_multi;

  localparam int unsigned NCH = 2;
  localparam int unsigned B   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             sync;
  logic [NCH*B-1:0] ratio_in;
  logic [NCH-1:0]   ratio_load;
  logic [NCH-1:0]   clkout;
  logic [NCH-1:0]   edge_rise;
  logic [NCH-1:0]   busy;

  typedef struct {
    logic [1:0] clk_e;
    logic [1:0] edg_e;
    logic [1:0] bsy_e;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  clk_divider_multi #(.NCH(NCH), .B(B), .DEFAULT_RATIO(3)) dut (
    .clkin      (clk),
    .reset      (rst),
    .enable     (enable),
    .sync       (sync),
    .ratio_in   (ratio_in),
    .ratio_load (ratio_load),
    .clkout     (clkout),
    .edge_rise  (edge_rise),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and queue the outputs
  // expected after the following rising edge. Bit order is {ch1, ch0}.
  task automatic step(input logic en, input logic sy, input logic [1:0] ld,
                      input logic [15:0] r0, input logic [15:0] r1,
                      input logic [1:0] ec, input logic [1:0] ee,
                      input logic [1:0] eb, input string tag);
    exp_t e;
    @(negedge clk);
    enable     = en;
    sync       = sy;
    ratio_load = ld;
    ratio_in   = {r1, r0};
    e.clk_e = ec; e.edg_e = ee; e.bsy_e = eb; e.tag = tag;
    q.push_back(e);
  endtask

  // Assert reset between clock edges; the expectation is checked right after.
  task automatic async_reset(input string tag);
    exp_t e;
    @(negedge clk);
    ratio_load = '0;
    sync       = 1'b0;
    e.clk_e = 2'b00; e.edg_e = 2'b00; e.bsy_e = 2'b00; e.tag = tag;
    q.push_back(e);
    #1 rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b0;
  endtask

  // Monitor: compare the DUT against the queue head after each rising edge
  // or asynchronous reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (clkout !== e.clk_e) begin
          n_err++;
          $display("FAIL %s clkout: got %b expected %b", e.tag, clkout, e.clk_e);
        end
        n_vec++;
        if (edge_rise !== e.edg_e) begin
          n_err++;
          $display("FAIL %s edge_rise: got %b expected %b", e.tag, edge_rise, e.edg_e);
        end
        n_vec++;
        if (busy !== e.bsy_e) begin
          n_err++;
          $display("FAIL %s busy: got %b expected %b", e.tag, busy, e.bsy_e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    sync       = 1'b0;
    ratio_load = '0;
    ratio_in   = '0;

    step(0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, "reset_state");
    @(posedge clk);
    #3 rst = 1'b0;

    // Default ratio 3: 1,0,0 on both channels.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 2'b00, 0, 0, 2'b11, 2'b11, 2'b00, "dflt_rise");
      step(1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, "dflt_low1");
      step(1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, "dflt_low2");
    end

    // ch0 ratio 8 loaded at counter=1; applied at the wrap.
    step(1, 0, 2'b00, 0, 0, 2'b11, 2'b11, 2'b00, "pre_load8");
    step(1, 0, 2'b01, 8, 0, 2'b00, 2'b00, 2'b01, "load8");
    step(1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, "apply8");
    step(1, 0, 2'b00, 0, 0, 2'b11, 2'b11, 2'b00, "r8_c0");
    step(1, 0, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, "r8_c1");
    step(1, 0, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, "r8_c2");
    step(1, 0, 2'b00, 0, 0, 2'b11, 2'b10, 2'b00, "r8_c3");
    step(1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, "r8_c4");
    step(1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, "r8_c5");
    step(1, 0, 2'b00, 0, 0, 2'b10, 2'b10, 2'b00, "r8_c6");
    step(1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, "r8_c7");

    // ch1 ratio 0 (clamped to 2) loaded on its wrap edge: applies one period later.
    step(1, 0, 2'b10, 0, 0, 2'b01, 2'b01, 2'b10, "load0_on_wrap");
    step(1, 0, 2'b00, 0, 0, 2'b11, 2'b10, 2'b10, "pend_hold1");
    step(1, 0, 2'b00, 0, 0, 2'b01, 2'b00, 2'b10, "pend_hold2");
    step(1, 0, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, "apply2");
    step(1, 0, 2'b00, 0, 0, 2'b10, 2'b10, 2'b00, "r2_a");
    step(1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, "r2_b");
    step(1, 0, 2'b00, 0, 0, 2'b10, 2'b10, 2'b00, "r2_c");
    step(1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, "r2_d");
    step(1, 0, 2'b00, 0, 0, 2'b11, 2'b11, 2'b00, "r2_r8_rise");

    // ch0 ratio 5, ch1 ratio 4 pending, then sync mid-period.
    step(1, 0, 2'b11, 5, 4, 2'b01, 2'b00, 2'b11, "load5_4");
    step(1, 0, 2'b00, 0, 0, 2'b11, 2'b10, 2'b11, "pre_sync");
    step(1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, "sync");
    step(1, 0, 2'b00, 0, 0, 2'b11, 2'b11, 2'b00, "post_sync_rise");
    step(1, 0, 2'b00, 0, 0, 2'b11, 2'b00, 2'b00, "ps_c1");
    step(1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, "ps_c2");
    step(1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, "ps_c3");
    step(1, 0, 2'b00, 0, 0, 2'b10, 2'b10, 2'b00, "ps_c4");
    step(1, 0, 2'b00, 0, 0, 2'b11, 2'b01, 2'b00, "ps_c5");
    step(1, 0, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, "ps_c6");

    // enable low for 10 cycles while ch0 is high; a load is still captured.
    for (int i = 0; i < 5; i++)
      step(0, 0, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, "hold");
    step(0, 0, 2'b10, 0, 6, 2'b01, 2'b00, 2'b10, "hold_load6");
    for (int i = 0; i < 4; i++)
      step(0, 0, 2'b00, 0, 0, 2'b01, 2'b00, 2'b10, "hold_pend");
    step(1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, "resume_apply6");
    step(1, 0, 2'b00, 0, 0, 2'b10, 2'b10, 2'b00, "resume_1");
    step(1, 0, 2'b00, 0, 0, 2'b10, 2'b00, 2'b00, "resume_2");
    step(1, 0, 2'b00, 0, 0, 2'b11, 2'b01, 2'b00, "resume_3");
    step(1, 0, 2'b10, 0, 9, 2'b01, 2'b00, 2'b10, "load9");

    // Asynchronous reset while busy; ratio back to 3 afterwards.
    async_reset("async_reset");
    step(1, 0, 2'b00, 0, 0, 2'b11, 2'b11, 2'b00, "rst_r3_rise");
    step(1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, "rst_r3_low1");
    step(1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, "rst_r3_low2");
    step(1, 0, 2'b00, 0, 0, 2'b11, 2'b11, 2'b00, "rst_r3_rise2");

    // sync with enable low and a same-edge load that must stay pending.
    step(0, 1, 2'b10, 0, 2, 2'b00, 2'b00, 2'b10, "sync_en0_load");
    step(1, 0, 2'b00, 0, 0, 2'b11, 2'b11, 2'b10, "sync_restart");
    step(1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b10, "sync_pend1");
    step(1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, "sync_apply2");
    step(1, 0, 2'b00, 0, 0, 2'b11, 2'b11, 2'b00, "mix_a");
    step(1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, "mix_b");
    step(1, 0, 2'b00, 0, 0, 2'b10, 2'b10, 2'b00, "mix_c");

    @(negedge clk);
    ratio_load = '0;
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
